// File: rtl/vout_timing_gen.sv
// HDMI video output timing generator: raster counters, registered HS/VS/DE and stream-fed RGB888 pixels.
// Optional internal colour-bar source enabled by defining VOUT_TESTPAT_EN (adds testpat_i).
module vout_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
`ifdef VOUT_TESTPAT_EN
    input  logic        testpat_i,
`endif
    input  logic [23:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        sof_o,
    output logic        underflow_o,
    input  logic        clr_i,
    output logic        vout_clk_o,
    output logic        vout_de_o,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic [23:0] vout_data_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    int            w_hPos;
    int            w_vPos;
    logic          w_active;
    logic          w_de;
    logic          w_testpat;
    logic          w_hsNext;
    logic          w_vsNext;
    logic [23:0]   w_dataNext;
    logic          r_underflow;

    assign w_hPos   = int'(r_hcnt);
    assign w_vPos   = int'(r_vcnt);
    assign w_active = (w_hPos < H_ACTIVE) && (w_vPos < V_ACTIVE);
    assign w_de     = en_i & w_active;

`ifdef VOUT_TESTPAT_EN
    assign w_testpat = testpat_i;
`else
    assign w_testpat = 1'b0;
`endif

    assign pix_ready_o = w_de & ~w_testpat;
    assign sof_o       = en_i && (w_hPos == 0) && (w_vPos == 0);
    assign vout_clk_o  = clk_i;
    assign underflow_o = r_underflow;

    // Counters sit at the origin while disabled so a rising en_i begins at pixel (0,0) immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!en_i) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hPos == H_TOTAL - 1) begin
            r_hcnt <= '0;
            if (w_vPos == V_TOTAL - 1) begin
                r_vcnt <= '0;
            end else begin
                r_vcnt <= r_vcnt + VW'(1);
            end
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    assign w_hsNext = (en_i && (w_hPos >= HS_START) && (w_hPos < HS_END)) ? HS_POL : ~HS_POL;
    assign w_vsNext = (en_i && (w_vPos >= VS_START) && (w_vPos < VS_END)) ? VS_POL : ~VS_POL;

`ifdef VOUT_TESTPAT_EN
    logic [2:0]  w_barIdx;
    logic [23:0] w_barColour;

    always_comb begin
        w_barIdx = 3'((w_hPos * 8) / H_ACTIVE);
        case (w_barIdx)
            3'd0:    w_barColour = 24'hFFFFFF;
            3'd1:    w_barColour = 24'hFFFF00;
            3'd2:    w_barColour = 24'h00FFFF;
            3'd3:    w_barColour = 24'h00FF00;
            3'd4:    w_barColour = 24'hFF00FF;
            3'd5:    w_barColour = 24'hFF0000;
            3'd6:    w_barColour = 24'h0000FF;
            default: w_barColour = 24'h000000;
        endcase
    end
`endif

    always_comb begin
        w_dataNext = 24'h000000;
`ifdef VOUT_TESTPAT_EN
        if (w_de && w_testpat) begin
            w_dataNext = w_barColour;
        end else
`endif
        if (pix_ready_o && pix_valid_i) begin
            w_dataNext = pix_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vout_de_o   <= 1'b0;
            vout_hs_o   <= ~HS_POL;
            vout_vs_o   <= ~VS_POL;
            vout_data_o <= 24'h000000;
        end else begin
            vout_de_o   <= w_de;
            vout_hs_o   <= w_hsNext;
            vout_vs_o   <= w_vsNext;
            vout_data_o <= w_dataNext;
        end
    end

    // A starved active pixel wins over a simultaneous clear so no underflow event is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_underflow <= 1'b0;
        end else if (pix_ready_o && !pix_valid_i) begin
            r_underflow <= 1'b1;
        end else if (clr_i) begin
            r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vout_timing_gen.sv
// Directed bench for vout_timing_gen on a small 8x6 raster, with a one-deep scoreboard
// holding the registered outputs predicted from each cycle's stimulus.
module tb_vout_timing_gen;

    localparam int H_ACT = 4, H_FP = 1, H_SY = 2, H_BP = 1;
    localparam int V_ACT = 3, V_FP = 1, V_SY = 1, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;

    typedef struct {
        logic        de;
        logic [23:0] data;
        logic        hs;
        logic        vs;
        logic        uf;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        testpat_i = 1'b0;
    logic [23:0] pix_data_i = '0;
    logic        pix_valid_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        pix_ready_o, sof_o, underflow_o, vout_clk_o;
    logic        vout_de_o, vout_hs_o, vout_vs_o;
    logic [23:0] vout_data_o;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   mh = 0, mv = 0;
    logic mu = 1'b0;
    int   sofCount = 0;
    exp_t sb[$];

    vout_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
`ifdef VOUT_TESTPAT_EN
        .testpat_i(testpat_i),
`endif
        .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .sof_o(sof_o), .underflow_o(underflow_o), .clr_i(clr_i), .vout_clk_o(vout_clk_o),
        .vout_de_o(vout_de_o), .vout_hs_o(vout_hs_o), .vout_vs_o(vout_vs_o),
        .vout_data_o(vout_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] barColour(input int x);
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return bars[(x * 8) / H_ACT];
    endfunction

    // Called just after a rising edge; drives one cycle and checks both comb and registered results.
    task automatic applyStimulus(input logic en, input logic valid, input logic [23:0] data,
                                 input logic clr, input logic tp);
        exp_t e, got;
        logic active, ready;
        en_i = en; pix_valid_i = valid; pix_data_i = data; clr_i = clr; testpat_i = tp;
        #1;
        active = en && (mh < H_ACT) && (mv < V_ACT);
`ifdef VOUT_TESTPAT_EN
        ready = active && !tp;
`else
        ready = active;
`endif
        checkOutput("pix_ready", pix_ready_o, ready);
        checkOutput("sof", sof_o, en && mh == 0 && mv == 0);
        if (sof_o) sofCount++;
        e.de   = active;
        e.data = (active && tp) ? barColour(mh) : (ready && valid) ? data : 24'h0;
        e.hs   = en && (mh >= H_ACT + H_FP) && (mh < H_ACT + H_FP + H_SY);
        e.vs   = en && (mv >= V_ACT + V_FP) && (mv < V_ACT + V_FP + V_SY);
        mu     = (ready && !valid) ? 1'b1 : clr ? 1'b0 : mu;
        e.uf   = mu;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb.pop_front();
        checkOutput("vout_de", vout_de_o, got.de);
        checkOutput("vout_data", vout_data_o, got.data);
        checkOutput("vout_hs", vout_hs_o, got.hs);
        checkOutput("vout_vs", vout_vs_o, got.vs);
        checkOutput("underflow", underflow_o, got.uf);
        checkOutput("vout_clk", vout_clk_o, clk_i);
        if (!en) begin
            mh = 0; mv = 0;
        end else if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_de"}, vout_de_o, 1'b0);
        checkOutput({tag, "_data"}, vout_data_o, 24'h0);
        checkOutput({tag, "_hs"}, vout_hs_o, 1'b0);
        checkOutput({tag, "_vs"}, vout_vs_o, 1'b0);
        checkOutput({tag, "_uf"}, underflow_o, 1'b0);
    endtask

    initial begin
        #13;
        checkResetValues("reset");
        #10 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Two full frames of streaming pixels tagged with their coordinates.
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++)
            applyStimulus(1'b1, 1'b1, {8'($urandom), 8'(mv), 8'(mh)}, 1'b0, 1'b0);
        checkOutput("sof_count", sofCount, 2);

        // Starve pixel (2,1), let the flag stick, then clear it.
        for (int i = 0; i < H_TOT * V_TOT; i++)
            applyStimulus(1'b1, !(mh == 2 && mv == 1), {8'hC3, 8'(mv), 8'(mh)}, 1'b0, 1'b0);
        checkOutput("uf_sticky", underflow_o, 1'b1);
        applyStimulus(1'b1, 1'b1, 24'h123456, 1'b1, 1'b0);
        // Starve and clear together: the set must win.
        while (!(mh == 1 && mv == 0)) applyStimulus(1'b1, 1'b1, 24'h0000AA, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 24'h0000BB, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 24'h0000CC, 1'b1, 1'b0);

        // Disable mid-line 2 for 10 clocks, then restart from the origin.
        while (!(mh == 2 && mv == 2)) applyStimulus(1'b1, 1'b1, 24'h00A5A5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        for (int i = 0; i < H_TOT * V_TOT + 3; i++)
            applyStimulus(1'b1, 1'b1, {8'h5A, 8'(mv), 8'(mh)}, 1'b0, 1'b0);

        // Asynchronous reset while an active pixel is being shown.
        while (!(mh == 2 && mv == 1)) applyStimulus(1'b1, 1'b1, {8'h77, 8'(mv), 8'(mh)}, 1'b0, 1'b0);
        checkOutput("pre_reset_de", vout_de_o, 1'b1);
        #3 rst_ni = 1'b0;
        #1;
        checkResetValues("async_reset");
        mh = 0; mv = 0; mu = 1'b0;
        sb.delete();
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkResetValues("held_reset");
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < H_TOT + 2; i++)
            applyStimulus(1'b1, 1'b1, {8'h99, 8'(mv), 8'(mh)}, 1'b0, 1'b0);

`ifdef VOUT_TESTPAT_EN
        // Colour bars replace the stream; valid held low must not flag underflow.
        while (!(mh == 0 && mv == 0)) applyStimulus(1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
        for (int i = 0; i < H_TOT * V_TOT; i++)
            applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("tp_no_uf", underflow_o, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
